rr_select_arbiter: RTL and testbench
====================================

RR_SELECT_ARBITER -- requirements
Module: rr_select_arbiter

Interface
REQ-001 SHALL have parameter N, default 4: number of requesters, equal to the data-input count of the downstream N:1 mux.
REQ-002 SHALL have parameter P, default $clog2(N): select width, equal to the downstream mux select width.
REQ-003 SHALL have parameter MAX_HOLD, default 8: maximum grant duration in cycles, legal range 1..255.
REQ-004 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port req  input  N  per-requester request level; bit i requests mux input i.
REQ-007 SHALL have port done  input  1  granted requester finished; level sampled each cycle while granted.
REQ-008 SHALL have port sel  output  P  registered index of the granted requester; drives the downstream mux S.
REQ-009 SHALL have port grant  output  N  registered one-hot grant vector.
REQ-010 SHALL have port valid  output  1  high while a grant is held; downstream mux output Y is meaningful only when valid=1.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse on a forced release at MAX_HOLD.

Function
REQ-012 SHALL implement the two-state FSM IDLE and GRANT.
REQ-013 SHALL, in IDLE with req != 0, select the first set req bit searching upward from (last+1) mod N with wrap-around, and enter GRANT at the next edge.
REQ-014 SHALL, in IDLE with req == 0, remain in IDLE with valid=0.
REQ-015 SHALL register sel, grant and valid together, giving a latency of exactly one cycle from a sampled req to valid=1.
REQ-016 SHALL hold grant = 1<<sel and valid=1 for every cycle in GRANT.
REQ-017 SHALL drive sel=0 and grant=0 whenever valid=0.
REQ-018 SHALL keep hold_cnt at 0 on grant entry and increment it by 1 each GRANT cycle; hold_cnt SHALL be wide enough for MAX_HOLD-1.
REQ-019 SHALL release the grant (return to IDLE, valid=0 next edge) on any of three conditions: done=1; req[sel]=0; or hold_cnt==MAX_HOLD-1.
REQ-020 SHALL pulse timeout=1 for one cycle, aligned with valid falling, only when the hold_cnt limit causes the release and neither done=1 nor req[sel]=0 in that cycle.
REQ-021 SHALL, on release, load last with sel, so the released requester has lowest priority at the next arbitration.
REQ-022 SHALL spend at least one IDLE cycle between consecutive grants (valid low for at least one cycle), with no back-to-back re-grant.
REQ-023 SHALL treat changes in req bits other than req[sel] during GRANT as having no effect until the next IDLE arbitration.
REQ-024 SHALL, with MAX_HOLD=1, release every grant after exactly one valid cycle, pulsing timeout when done=0 and req[sel]=1.
REQ-025 SHALL never assert more than one grant bit.
REQ-026 SHALL keep sel < N at all times when valid=1.

Reset
REQ-027 SHALL, on rst_n=0, immediately and asynchronously force state=IDLE, valid=0, grant=0, sel=0, timeout=0, hold_cnt=0 and last=N-1, so requester 0 has first priority.
REQ-028 SHALL apply reset asserted mid-grant immediately without waiting for a clock edge, and SHALL not restore the grant after reset deasserts.
REQ-029 SHALL evaluate the first arbitration after reset deassertion on the first rising edge with rst_n=1.

Verification
REQ-030 SHALL verify the following (N=4, MAX_HOLD=8): reset released with req=4'b1111 -> next edge valid=1, sel=0, grant=4'b0001.
REQ-031 SHALL verify: req=4'b1111 held and done pulsed 1 cycle after each grant -> sel sequence 0,1,2,3,0, each grant separated by one valid=0 cycle.
REQ-032 SHALL verify: req=4'b0100 held with done=0 -> valid high for exactly 8 cycles, timeout=1 on the falling cycle, then re-grant sel=2 after one idle cycle.
REQ-033 SHALL verify: granted sel=1, req[1] dropped on cycle 3 of the grant -> valid=0 next edge, timeout=0, next arbitration starts search at index 2.
REQ-034 SHALL verify: rst_n pulled low mid-grant between clock edges -> valid, grant, sel and timeout are 0 before the next edge; after release with req=4'b1000 -> sel=3.
REQ-035 SHALL verify: done=1 and hold_cnt==7 in the same cycle -> single release, timeout=0.

Source files
------------

// File: rtl/rr_select_arbiter.sv
// Round-robin arbiter driving the select of a downstream N:1 mux.
// One grant at a time, released on done, request drop or hold limit.
module rr_select_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned P        = $clog2(N),
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [N-1:0] req,
  input  logic         done,
  output logic [P-1:0] sel,
  output logic [N-1:0] grant,
  output logic         valid,
  output logic         timeout
);

  localparam int unsigned    HW        = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0]  HOLD_LAST = HW'(MAX_HOLD - 1);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t        r_state;
  logic [P-1:0]  r_sel;
  logic [N-1:0]  r_grant;
  logic          r_valid;
  logic          r_timeout;
  logic [HW-1:0] r_hold_cnt;
  logic [P-1:0]  r_last;

  logic [P-1:0]  w_pick;
  logic [P-1:0]  w_idx;
  logic          w_found;
  logic          w_req_sel;
  logic          w_limit;
  logic          w_release;

  // First set request searching upward from the one after the last grant.
  always_comb begin
    w_pick  = '0;
    w_idx   = '0;
    w_found = 1'b0;
    for (int unsigned k = 1; k <= N; k++) begin
      w_idx = P'((32'(r_last) + k) % N);
      if (!w_found && req[w_idx]) begin
        w_pick  = w_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_req_sel = req[r_sel];
  assign w_limit   = (r_hold_cnt == HOLD_LAST);
  assign w_release = done | ~w_req_sel | w_limit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_sel      <= '0;
      r_grant    <= '0;
      r_valid    <= 1'b0;
      r_timeout  <= 1'b0;
      r_hold_cnt <= '0;
      r_last     <= P'(N - 1);
    end else begin
      case (r_state)
        S_IDLE: begin
          r_timeout  <= 1'b0;
          r_hold_cnt <= '0;
          if (w_found) begin
            r_state <= S_GRANT;
            r_sel   <= w_pick;
            r_grant <= N'(1) << w_pick;
            r_valid <= 1'b1;
          end
        end
        S_GRANT: begin
          if (w_release) begin
            r_state    <= S_IDLE;
            r_sel      <= '0;
            r_grant    <= '0;
            r_valid    <= 1'b0;
            r_hold_cnt <= '0;
            r_last     <= r_sel;
            // Timeout only when the hold limit alone forced the release.
            r_timeout  <= w_limit & ~done & w_req_sel;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
            r_timeout  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sel     = r_sel;
  assign grant   = r_grant;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_rr_select_arbiter.sv
// Scoreboarded bench for rr_select_arbiter (N=4, MAX_HOLD=8): directed
// stimulus pushes expected grants, a negedge monitor checks each completed grant.
module tb_rr_select_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [1:0] sel;
  logic [3:0] grant;
  logic       valid;
  logic       timeout;

  typedef struct {
    int         sel;
    logic [3:0] grant;
    int         len;
    int         to;
    int         gap;   // -1: idle gap before this grant not checked
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  rr_select_arbiter #(.N(4), .P(2), .MAX_HOLD(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .sel     (sel),
    .grant   (grant),
    .valid   (valid),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int s, input logic [3:0] g, input int len, input int to, input int gap);
    exp_t e;
    e.sel = s; e.grant = g; e.len = len; e.to = to; e.gap = gap;
    exp_q.push_back(e);
  endtask

  // Monitor: tracks each grant from valid rise to fall and scores it.
  bit   in_grant  = 1'b0;
  bit   gap_known = 1'b0;
  int   gap_cnt   = 0;
  int   cur_sel, cur_len, cur_gap;
  logic [3:0] cur_grant;

  always @(negedge clk) begin
    if (!rst_n) begin
      in_grant  = 1'b0;
      gap_known = 1'b0;
    end else if (valid) begin
      if (!in_grant) begin
        in_grant  = 1'b1;
        cur_sel   = int'(sel);
        cur_grant = grant;
        cur_len   = 0;
        cur_gap   = gap_known ? gap_cnt : -1;
      end
      cur_len++;
      chk("grant_stable", int'(grant), int'(cur_grant));
      chk("sel_stable", int'(sel), cur_sel);
      chk("timeout_low_while_valid", int'(timeout), 0);
    end else begin
      chk("idle_sel_zero", int'(sel), 0);
      chk("idle_grant_zero", int'(grant), 0);
      if (in_grant) begin
        in_grant = 1'b0;
        if (exp_q.size() == 0) begin
          chk("unexpected_grant_sel", cur_sel, -1);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("grant_sel", cur_sel, e.sel);
          chk("grant_vec", int'(cur_grant), int'(e.grant));
          chk("grant_len", cur_len, e.len);
          chk("timeout_on_fall", int'(timeout), e.to);
          if (e.gap >= 0) chk("idle_gap", cur_gap, e.gap);
        end
        gap_cnt   = 1;
        gap_known = 1'b1;
      end else begin
        gap_cnt++;
        chk("timeout_idle", int'(timeout), 0);
      end
    end
  end

  initial begin
    rst_n = 1'b1; req = 4'b0000; done = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_valid", int'(valid), 0);
    chk("rst_grant", int'(grant), 0);
    chk("rst_sel", int'(sel), 0);
    chk("rst_timeout", int'(timeout), 0);

    // Reset release with all requesting; done ends every grant after one cycle.
    tick(1);
    req = 4'b1111; done = 1'b1; rst_n = 1'b1;
    push(0, 4'b0001, 1, 0, -1);
    push(1, 4'b0010, 1, 0, 1);
    push(2, 4'b0100, 1, 0, 1);
    push(3, 4'b1000, 1, 0, 1);
    push(0, 4'b0001, 1, 0, 1);
    tick(1);
    chk("first_valid", int'(valid), 1);
    chk("first_sel", int'(sel), 0);
    tick(9);
    req = 4'b0000; done = 1'b0;

    // Single requester held: two hold-limit timeouts.
    tick(2);
    req = 4'b0100;
    push(2, 4'b0100, 8, 1, 3);
    push(2, 4'b0100, 8, 1, 1);
    tick(18);

    // Requester 1 drops on grant cycle 3; search restarts at index 2.
    req = 4'b0010;
    push(1, 4'b0010, 3, 0, 1);
    tick(3);
    req = 4'b1101;
    push(2, 4'b0100, 8, 0, 1);
    tick(4);
    req = 4'b1111;
    tick(5);
    done = 1'b1;                      // coincides with hold_cnt == 7
    tick(1);
    done = 1'b0; req = 4'b0000;

    // Asynchronous reset mid-grant.
    tick(2);
    req = 4'b0001;
    tick(1);
    chk("pre_reset_valid", int'(valid), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", int'(valid), 0);
    chk("async_grant", int'(grant), 0);
    chk("async_sel", int'(sel), 0);
    chk("async_timeout", int'(timeout), 0);
    tick(1);
    req = 4'b1000;
    tick(1);
    rst_n = 1'b1;
    push(3, 4'b1000, 3, 0, -1);
    #1;
    chk("no_regrant_before_edge", int'(valid), 0);
    tick(1);
    chk("post_reset_valid", int'(valid), 1);
    chk("post_reset_sel", int'(sel), 3);
    tick(2);
    req = 4'b0000;
    tick(3);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(posedge clk);
    chk("queue_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
